// File: rtl/hex_rotate_sched_pkg.sv
// Shared definitions for the HEX rotator sequencer.
// Character codes consumed by the char_7seg decoders, FSM state encodings,
// the power-on message and a slot-extraction helper.
package hex_rotate_sched_pkg;

  // 2-bit character codes understood by char_7seg
  localparam logic [1:0] CH_D     = 2'b00;
  localparam logic [1:0] CH_E     = 2'b01;
  localparam logic [1:0] CH_1     = 2'b10;
  localparam logic [1:0] CH_BLANK = 2'b11;

  // Message shown after reset: {Slot0,Slot1,Slot2,Slot3} = d,E,1,blank
  localparam logic [7:0] RESET_MSG_DEF = {CH_D, CH_E, CH_1, CH_BLANK};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Slot0 lives in the top bits of the packed message, Slot3 in the bottom bits.
  function automatic logic [1:0] slot_of(input logic [7:0] msg, input logic [1:0] idx);
    logic [1:0] res;
    case (idx)
      2'd0:    res = msg[7:6];
      2'd1:    res = msg[5:4];
      2'd2:    res = msg[3:2];
      default: res = msg[1:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hex_rotate_sched_tick_prescaler.sv
// Free-running divide-by-DIV prescaler producing a one-cycle Tick on wrap.
// Tick is combinational from the count and En; the count updates on the next edge.
// Clr wins over En; with En low the count simply holds.
module tick_prescaler #(
  parameter int DIV = 50_000_000,
  parameter int CW  = 26
) (
  input  logic Clock,
  input  logic Reset,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == CW'(DIV - 1));
  assign Tick   = En && at_top;

  // Next count: clear, wrap at DIV-1, increment, or hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      if (at_top) cnt_d = '0;
      else        cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_rotate_sched.sv
// Sequencer for the 4-position HEX rotator: message slots, rotation select, FSM.
// Char outputs are a combinational decode of registered state (zero latency).
// No handshake; Load overrides Run/Step/tick, Step is edge-detected and ignored in RUN.
module hex_rotate_sched
  import hex_rotate_sched_pkg::*;
#(
  parameter int         DIV       = 50_000_000,
  parameter int         CW        = 26,
  parameter logic [7:0] RESET_MSG = RESET_MSG_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] LoadData,
  input  logic       Run,
  input  logic       Step,
  input  logic       Dir,
  output logic [1:0] RotSel,
  output logic [1:0] Char3,
  output logic [1:0] Char2,
  output logic [1:0] Char1,
  output logic [1:0] Char0,
  output logic       Running,
  output logic       Tick
);

  state_t     state_q, state_d;
  logic [1:0] rot_sel_q, rot_sel_d;
  logic [7:0] msg_q, msg_d;
  logic       step_q, step_d;

  logic       step_rise;
  logic       enter_run;
  logic       advance;
  logic       presc_en;
  logic       presc_clr;
  logic       presc_tick;

  assign step_rise = Step && !step_q;

  // Prescaler only counts while running; a Load freezes it for the cycle it clears it
  assign presc_en  = (state_q == S_RUN) && !Load;
  assign presc_clr = Load || enter_run;

  tick_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_presc (
    .Clock (Clock),
    .Reset (Reset),
    .En    (presc_en),
    .Clr   (presc_clr),
    .Tick  (presc_tick)
  );

  // Next state, message and rotation select; Load beats everything else
  always_comb begin
    state_d   = state_q;
    rot_sel_d = rot_sel_q;
    msg_d     = msg_q;
    step_d    = Step;
    enter_run = 1'b0;
    advance   = 1'b0;
    if (Load) begin
      msg_d     = LoadData;
      rot_sel_d = 2'd0;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Run) begin
            state_d   = S_RUN;
            enter_run = 1'b1;
          end
        end
        S_RUN: begin
          if (!Run) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (Run) begin
            state_d   = S_RUN;
            enter_run = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A tick still advances on the cycle Run drops; Step only counts outside RUN
      advance = (state_q == S_RUN) ? presc_tick : step_rise;
      if (advance) begin
        rot_sel_d = Dir ? (rot_sel_q - 2'd1) : (rot_sel_q + 2'd1);
      end
    end
  end

  // State, rotation, message and Step history registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      rot_sel_q <= 2'd0;
      msg_q     <= RESET_MSG;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rot_sel_q <= rot_sel_d;
      msg_q     <= msg_d;
      step_q    <= step_d;
    end
  end

  // Display muxing: HEX3 shows the selected slot, lower displays the following ones
  always_comb begin
    Char3 = slot_of(msg_q, rot_sel_q);
    Char2 = slot_of(msg_q, rot_sel_q + 2'd1);
    Char1 = slot_of(msg_q, rot_sel_q + 2'd2);
    Char0 = slot_of(msg_q, rot_sel_q + 2'd3);
  end

  assign RotSel  = rot_sel_q;
  assign Running = (state_q == S_RUN);
  assign Tick    = presc_tick;

endmodule

// File: tb/tb_hex_rotate_sched.sv
// Directed test of hex_rotate_sched with DIV=4.
// Stimulus pushes hand-computed expected outputs; a negedge monitor pops and compares.
// Expectations are {RotSel, Char3..Char0, Running, Tick}.
module tb_hex_rotate_sched;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Load;
    logic [7:0] LoadData;
    logic       Run;
    logic       Step;
    logic       Dir;
    logic [1:0] RotSel;
    logic [1:0] Char3, Char2, Char1, Char0;
    logic       Running;
    logic       Tick;
    logic       done = 1'b0;

    hex_rotate_sched #(
        .DIV (4),
        .CW  (3)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (Load),
        .LoadData (LoadData),
        .Run      (Run),
        .Step     (Step),
        .Dir      (Dir),
        .RotSel   (RotSel),
        .Char3    (Char3),
        .Char2    (Char2),
        .Char1    (Char1),
        .Char0    (Char0),
        .Running  (Running),
        .Tick     (Tick)
    );

    always #5 Clock = ~Clock;

    // Hand-computed Char3..Char0 for each RotSel: reset message and loaded message 11100100
    logic [7:0] cr [4];
    logic [7:0] cl [4];
    initial begin
        cr[0] = 8'b00_01_10_11; cr[1] = 8'b01_10_11_00;
        cr[2] = 8'b10_11_00_01; cr[3] = 8'b11_00_01_10;
        cl[0] = 8'b11_10_01_00; cl[1] = 8'b10_01_00_11;
        cl[2] = 8'b01_00_11_10; cl[3] = 8'b00_11_10_01;
    end

    typedef struct {
        string       nm;
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: compare every queued expectation against the outputs at the falling edge
    always @(negedge Clock) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [11:0] got;
            e   = q.pop_front();
            got = {RotSel, Char3, Char2, Char1, Char0, Running, Tick};
            n_vec++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s: got rs=%b ch=%b run=%b tick=%b, expected rs=%b ch=%b run=%b tick=%b",
                         e.nm, got[11:10], got[9:2], got[1], got[0],
                         e.v[11:10], e.v[9:2], e.v[1], e.v[0]);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded time
    initial begin
        #20000;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: stimulus did not complete");
            $finish;
        end
    end

    // Immediate check of the reset values, independent of the monitor queue
    task automatic check_reset_state(input string nm);
        n_vec++;
        if (RotSel !== 2'd0 || {Char3, Char2, Char1, Char0} !== 8'b00_01_10_11 ||
            Running !== 1'b0 || Tick !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: reset state rs=%b ch=%b run=%b tick=%b", nm,
                     RotSel, {Char3, Char2, Char1, Char0}, Running, Tick);
        end
    endtask

    // Queue the expectation for the current cycle
    task automatic expect_now(input string nm, input logic [1:0] rs, input logic [7:0] ch,
                              input logic rn, input logic tk);
        exp_t e;
        e.nm = nm;
        e.v  = {rs, ch, rn, tk};
        q.push_back(e);
    endtask

    // Queue expectation, then move to just after the next rising edge
    task automatic cyc(input string nm, input logic [1:0] rs, input logic [7:0] ch,
                       input logic rn, input logic tk);
        expect_now(nm, rs, ch, rn, tk);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; LoadData = 8'h00; Run = 1'b0; Step = 1'b0; Dir = 1'b0;
        #1;
        check_reset_state("reset_initial");
        cyc("reset_hold", 2'd0, cr[0], 1'b0, 1'b0);
        cyc("reset_hold", 2'd0, cr[0], 1'b0, 1'b0);
        Reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 4; i++) cyc("idle", 2'd0, cr[0], 1'b0, 1'b0);

        // 2: auto-rotate up; ticks on the 4th RUN cycle of each period
        Run = 1'b1;
        cyc("enter_run", 2'd0, cr[0], 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                cyc("run_up", 2'(p), cr[p], 1'b1, (c == 3));
            end
        end

        // 3: rotate down from 0 wraps to 3
        Dir = 1'b1;
        for (int c = 0; c < 4; c++) cyc("run_down", 2'd0, cr[0], 1'b1, (c == 3));

        // 4: pause, RotSel frozen, no tick
        Run = 1'b0;
        cyc("run_drop", 2'd3, cr[3], 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc("pause_hold", 2'd3, cr[3], 1'b0, 1'b0);
        Dir  = 1'b0;
        Step = 1'b1;
        cyc("step_held_first", 2'd3, cr[3], 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc("step_held", 2'd0, cr[0], 1'b0, 1'b0);
        Step = 1'b0; cyc("step_lo", 2'd0, cr[0], 1'b0, 1'b0);
        Step = 1'b1; cyc("step_p1", 2'd0, cr[0], 1'b0, 1'b0);
        Step = 1'b0; cyc("step_lo", 2'd1, cr[1], 1'b0, 1'b0);
        Step = 1'b1; cyc("step_p2", 2'd1, cr[1], 1'b0, 1'b0);
        Step = 1'b0; cyc("step_twice", 2'd2, cr[2], 1'b0, 1'b0);
        // Step pulses while running are ignored
        Run = 1'b1;
        cyc("resume", 2'd2, cr[2], 1'b0, 1'b0);
        Step = 1'b1; cyc("run_step", 2'd2, cr[2], 1'b1, 1'b0);
        Step = 1'b0; cyc("run_step", 2'd2, cr[2], 1'b1, 1'b0);
        Step = 1'b1; cyc("run_step", 2'd2, cr[2], 1'b1, 1'b0);
        Step = 1'b0; cyc("run_step_tick", 2'd2, cr[2], 1'b1, 1'b1);

        // 5: walk down to RotSel=2, then Load mid-run
        Dir = 1'b1;
        for (int c = 0; c < 4; c++) cyc("run_down2", 2'd3, cr[3], 1'b1, (c == 3));
        Load = 1'b1; LoadData = 8'b11100100;
        cyc("load_cycle", 2'd2, cr[2], 1'b1, 1'b0);
        Load = 1'b0;
        cyc("after_load_idle", 2'd0, cl[0], 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) cyc("run_loaded", 2'd0, cl[0], 1'b1, 1'b0);
        Load = 1'b1;
        cyc("load_on_tick", 2'd0, cl[0], 1'b1, 1'b0);
        Load = 1'b0; Run = 1'b0;
        cyc("load_no_adv", 2'd0, cl[0], 1'b0, 1'b0);
        cyc("load_no_adv", 2'd0, cl[0], 1'b0, 1'b0);

        // 6: reach RotSel=3, prescaler=2, then reset mid-count
        Step = 1'b1; cyc("step_down", 2'd0, cl[0], 1'b0, 1'b0);
        Step = 1'b0; cyc("step_down", 2'd3, cl[3], 1'b0, 1'b0);
        Run = 1'b1;
        cyc("enter_run2", 2'd3, cl[3], 1'b0, 1'b0);
        cyc("cnt0", 2'd3, cl[3], 1'b1, 1'b0);
        cyc("cnt1", 2'd3, cl[3], 1'b1, 1'b0);
        Reset = 1'b1;
        #1;
        check_reset_state("reset_mid_immediate");
        cyc("reset_mid", 2'd0, cr[0], 1'b0, 1'b0);
        Reset = 1'b0; Dir = 1'b0;
        cyc("rerun_enter", 2'd0, cr[0], 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) cyc("rerun", 2'd0, cr[0], 1'b1, (c == 3));
        cyc("rerun_adv", 2'd1, cr[1], 1'b1, 1'b0);

        @(negedge Clock);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never compared", q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        if (n_fail == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule
